alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multicycle control FSM that drives the A/B operand registers, ALU input muxes, ALU opcode and ALUOut register write of the A_B_and_ALU datapath. One request is accepted at a time over a Start/Busy/Done handshake, and each request runs as a fixed LOAD → EXEC → WB sequence. The block samples the datapath Zero/OverFlow flags into status outputs, can suppress writeback on overflow, and rejects reserved mux encodings. It sits between the processor's main control unit and the datapath.

## Interface
Parameters:
- None. All widths are fixed to match the datapath: 3-bit A-select, 2-bit B-select, 3-bit opcode.

Ports:
- Clock  in  1  single system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  request valid; sampled only in IDLE
- ReqAsel  in  3  ALU A-input select for the request
- ReqBsel  in  2  ALU B-input select; 3 is reserved
- ReqOp  in  3  ALU opcode
- ReqLoadAB  in  1  1 = run the LOAD cycle (write A and B) before EXEC
- ReqTrapOvf  in  1  1 = suppress ALUOutWrite if OverFlow is seen in EXEC
- Zero  in  1  datapath ALU zero flag (combinational)
- OverFlow  in  1  datapath ALU overflow flag (combinational)
- AWrite, BWrite  out  1  operand register write enables
- ALUAinput  out  3  A mux select to datapath
- ALUBinput  out  2  B mux select to datapath
- ALUOp  out  3  opcode to datapath
- ALUOutWrite  out  1  ALUOut register write enable
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle completion pulse
- ZeroFlag, OvfFlag  out  1  registered flags from the last EXEC
- Error  out  1  registered; set on reject or trapped overflow, cleared on next accept

## Operation
- States: IDLE, LOAD, EXEC, WB, REJECT. Outputs are Moore (decoded from state plus captured request fields).
- Accept: in IDLE with Start=1, register ReqAsel, ReqBsel, ReqOp, ReqLoadAB and ReqTrapOvf, and clear Error.
- Next state after accept:
  - REJECT if ReqBsel=3;
  - otherwise LOAD if ReqLoadAB=1;
  - otherwise EXEC.
- LOAD: AWrite=BWrite=1; mux selects and ALUOp drive 0. Next state is EXEC.
- EXEC: ALUAinput, ALUBinput and ALUOp drive the captured fields; all write enables are 0. At the exit edge, ZeroFlag←Zero and OvfFlag←OverFlow. Next state is WB.
- WB: selects and opcode stay held, so the ALU output is stable while it is written.
  - ALUOutWrite = ~(trap & OvfFlag).
  - Done=1.
  - If a trap suppresses the write, Error←1 at the exit edge.
  - Next state is IDLE.
- REJECT: Done=1; no write enables; Error←1 at the exit edge. ZeroFlag and OvfFlag are unchanged. Next state is IDLE.
- IDLE: all write enables 0, selects and opcode 0, Busy=0, Done=0.
- Start outside IDLE is ignored, not queued. The requester must hold Start until it sees Busy=1, or pulse it while Busy=0.

## Timing
- Reset at a rising edge forces the following, regardless of current state (including mid-LOAD or mid-WB):
  - state = IDLE;
  - all outputs = 0, including ZeroFlag, OvfFlag and Error.
- Reset has priority over Start in the same cycle.
- Latency from the accept edge to the Done cycle:
  - 3 cycles with LOAD (LOAD, EXEC, WB);
  - 2 cycles without LOAD;
  - 1 cycle for REJECT.
- Back-to-back: Start may be high in the cycle after WB (IDLE), giving a minimum 1-cycle Busy gap between requests.
- A and B register contents are written at the LOAD exit edge, so EXEC sees the new operands.
- ALUOutReg updates at the WB exit edge.
- Zero and OverFlow are sampled only at the EXEC exit edge; their values in other states are don't-care.
- Done is high for exactly one cycle per accepted request. Busy is high from the cycle after accept through the Done cycle, inclusive.

## Test plan
- Reset, then Start with Asel=1, Bsel=1, Op=1, LoadAB=1 → Busy high for 3 cycles; AWrite=BWrite=1 in cycle 1; selects 1/1/1 in cycles 2–3; ALUOutWrite=1 and Done=1 in cycle 3; datapath ALUOutReg=expected sum.
- Start with LoadAB=0, Asel=3, Bsel=2, Op=4, operands making ALU result 0 → Done in cycle 2; ZeroFlag=1, OvfFlag=0, ALUOutWrite=1.
- Overflowing subtract (A=16'h7234, B-path=16'ha234, Op=4) with TrapOvf=1 → OvfFlag=1, ALUOutWrite=0 in WB, Error=1, ALUOutReg unchanged. Repeat with TrapOvf=0 → write occurs and Error=0.
- Start with Bsel=3 → REJECT: Done after 1 cycle, Error=1, no write enable ever asserted, ZeroFlag and OvfFlag unchanged.
- Start held high continuously → requests accepted every 4th cycle (LOAD=1 case); no Start accepted while Busy=1.
- Reset asserted during EXEC → next cycle: IDLE, Busy=0, all enables 0, flags 0, no Done pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multicycle LOAD/EXEC/WB sequencer for the A_B_and_ALU datapath.
// One request at a time over Start/Busy/Done; all outputs registered.
module alu_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] ReqAsel,
  input  logic [1:0] ReqBsel,
  input  logic [2:0] ReqOp,
  input  logic       ReqLoadAB,
  input  logic       ReqTrapOvf,
  input  logic       Zero,
  input  logic       OverFlow,
  output logic       AWrite,
  output logic       BWrite,
  output logic [2:0] ALUAinput,
  output logic [1:0] ALUBinput,
  output logic [2:0] ALUOp,
  output logic       ALUOutWrite,
  output logic       Busy,
  output logic       Done,
  output logic       ZeroFlag,
  output logic       OvfFlag,
  output logic       Error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    WB,
    REJECT
  } state_t;

  state_t     state;
  logic [2:0] asel;
  logic [1:0] bsel;
  logic [2:0] op;
  logic       trap;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      asel        <= '0;
      bsel        <= '0;
      op          <= '0;
      trap        <= 1'b0;
      AWrite      <= 1'b0;
      BWrite      <= 1'b0;
      ALUAinput   <= '0;
      ALUBinput   <= '0;
      ALUOp       <= '0;
      ALUOutWrite <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      ZeroFlag    <= 1'b0;
      OvfFlag     <= 1'b0;
      Error       <= 1'b0;
    end else begin
      AWrite      <= 1'b0;
      BWrite      <= 1'b0;
      ALUOutWrite <= 1'b0;
      Done        <= 1'b0;
      unique case (state)
        IDLE: begin
          ALUAinput <= '0;
          ALUBinput <= '0;
          ALUOp     <= '0;
          if (Start) begin
            asel  <= ReqAsel;
            bsel  <= ReqBsel;
            op    <= ReqOp;
            trap  <= ReqTrapOvf;
            Error <= 1'b0;
            Busy  <= 1'b1;
            if (ReqBsel == 2'd3) begin
              state <= REJECT;
              Done  <= 1'b1;
            end else if (ReqLoadAB) begin
              state  <= LOAD;
              AWrite <= 1'b1;
              BWrite <= 1'b1;
            end else begin
              state     <= EXEC;
              ALUAinput <= ReqAsel;
              ALUBinput <= ReqBsel;
              ALUOp     <= ReqOp;
            end
          end
        end
        LOAD: begin
          state     <= EXEC;
          ALUAinput <= asel;
          ALUBinput <= bsel;
          ALUOp     <= op;
        end
        EXEC: begin
          // WB write enable is decided from the live flag at this edge
          state       <= WB;
          ZeroFlag    <= Zero;
          OvfFlag     <= OverFlow;
          ALUOutWrite <= ~(trap & OverFlow);
          Done        <= 1'b1;
        end
        WB: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          ALUAinput <= '0;
          ALUBinput <= '0;
          ALUOp     <= '0;
          if (trap & OvfFlag) Error <= 1'b1;
        end
        REJECT: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Error <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed vector bench for alu_sequencer.
// Zero/OverFlow read inverted outside EXEC so wrong-cycle sampling shows.
module tb_alu_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, Start;
  logic [2:0] ReqAsel;
  logic [1:0] ReqBsel;
  logic [2:0] ReqOp;
  logic       ReqLoadAB, ReqTrapOvf;
  logic       Zero, OverFlow;
  logic       AWrite, BWrite;
  logic [2:0] ALUAinput;
  logic [1:0] ALUBinput;
  logic [2:0] ALUOp;
  logic       ALUOutWrite, Busy, Done;
  logic       ZeroFlag, OvfFlag, Error;

  logic vz = 1'b0;
  logic vo = 1'b0;
  logic in_exec;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  assign in_exec  = Busy & ~Done & ~AWrite;
  assign Zero     = in_exec ? vz : ~vz;
  assign OverFlow = in_exec ? vo : ~vo;

  alu_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .ReqAsel(ReqAsel), .ReqBsel(ReqBsel), .ReqOp(ReqOp),
    .ReqLoadAB(ReqLoadAB), .ReqTrapOvf(ReqTrapOvf),
    .Zero(Zero), .OverFlow(OverFlow),
    .AWrite(AWrite), .BWrite(BWrite),
    .ALUAinput(ALUAinput), .ALUBinput(ALUBinput), .ALUOp(ALUOp),
    .ALUOutWrite(ALUOutWrite), .Busy(Busy), .Done(Done),
    .ZeroFlag(ZeroFlag), .OvfFlag(OvfFlag), .Error(Error)
  );

  typedef struct {
    logic [2:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic       load;
    logic       trap;
    logic       z;
    logic       o;
    int         lat;
    logic       wr;
    logic       err;
    logic       zf;
    logic       of;
  } vec_t;

  vec_t vt[8];

  function automatic logic [12:0] outs();
    return {AWrite, BWrite, ALUAinput, ALUBinput, ALUOp,
            ALUOutWrite, Busy, Done};
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    logic [12:0] e;
    @(negedge Clock);
    ReqAsel = v.a; ReqBsel = v.b; ReqOp = v.op;
    ReqLoadAB = v.load; ReqTrapOvf = v.trap;
    vz = v.z; vo = v.o;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) @(negedge Clock);
      if (v.lat == 1)
        e = 13'b0_0_000_00_000_0_1_1;
      else if (v.load && c == 1)
        e = 13'b1_1_000_00_000_0_1_0;
      else if (c == v.lat)
        e = {2'b00, v.a, v.b, v.op, v.wr, 2'b11};
      else
        e = {2'b00, v.a, v.b, v.op, 3'b010};
      chk($sformatf("v%0d c%0d outs", idx, c), 16'(outs()), 16'(e));
    end
    @(negedge Clock);
    chk($sformatf("v%0d idle", idx), 16'(outs()), 16'h0);
    chk($sformatf("v%0d flags", idx), {13'b0, ZeroFlag, OvfFlag, Error},
        {13'b0, v.zf, v.of, v.err});
  endtask

  initial begin
    vt[0] = '{3'd1, 2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{3'd3, 2'd2, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{3'd2, 2'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{3'd2, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{3'd5, 2'd3, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{3'd4, 2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{3'd7, 2'd3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{3'd6, 2'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1};

    // reset wins over a simultaneous Start
    Reset = 1'b1; Start = 1'b1;
    ReqAsel = 3'd1; ReqBsel = 2'd1; ReqOp = 3'd1;
    ReqLoadAB = 1'b1; ReqTrapOvf = 1'b0;
    repeat (2) @(negedge Clock);
    chk("reset outs", 16'(outs()), 16'h0);
    chk("reset flags", {13'b0, ZeroFlag, OvfFlag, Error}, 16'h0);
    Start = 1'b0;
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) run(i, vt[i]);

    // reset in the middle of EXEC, flags currently all set
    @(negedge Clock);
    ReqAsel = 3'd2; ReqBsel = 2'd2; ReqOp = 3'd5;
    ReqLoadAB = 1'b0; ReqTrapOvf = 1'b0;
    vz = 1'b1; vo = 1'b1;
    Start = 1'b1;
    @(negedge Clock);
    chk("pre-reset exec", 16'(outs()), 16'({2'b00, 3'd2, 2'd2, 3'd5, 3'b010}));
    Reset = 1'b1;
    @(negedge Clock);
    chk("exec reset outs", 16'(outs()), 16'h0);
    chk("exec reset flags", {13'b0, ZeroFlag, OvfFlag, Error}, 16'h0);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clock);
    chk("post reset no done", 16'(outs()), 16'h0);

    // Start held: accepts every 4th edge with LOAD
    ReqAsel = 3'd1; ReqBsel = 2'd0; ReqOp = 3'd2;
    ReqLoadAB = 1'b1; ReqTrapOvf = 1'b0;
    vz = 1'b0; vo = 1'b1;
    Start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      if (k == 12) Start = 1'b0;
      chk($sformatf("held k%0d", k), {14'b0, Busy, Done},
          {14'b0, (k % 4) != 0, (k % 4) == 3});
    end
    @(negedge Clock);
    chk("held end", 16'(outs()), 16'h0);
    chk("held flags", {13'b0, ZeroFlag, OvfFlag, Error}, 16'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
